// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared types and defaults for the PWM-DAC successive-approximation ADC
// Contents:
//   ADC_DATA_W, ADC_SETTLE_CYCLES, ADC_SYNC_STAGES : default resolution, RC settle time, sync depth
//   sar_state_t                                    : SAR sequencer states
package adc_pkg;

   localparam int ADC_DATA_W        = 8;
   localparam int ADC_SETTLE_CYCLES = 4096;
   localparam int ADC_SYNC_STAGES   = 2;

   typedef enum logic [2:0] {
      IDLE,
      SET,
      SETTLE,
      SAMPLE,
      DONE
   } sar_state_t;

endpackage

// File: rtl/bit_sync.sv
// rtl/bit_sync.sv - multi-stage flip-flop synchroniser for a single asynchronous input
// Ports:
//   clk   in  1 : destination clock
//   reset in  1 : synchronous, active-low; clears every stage
//   din   in  1 : asynchronous input
//   dout  out 1 : synchronised copy of din, STAGES clocks late
module bit_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic dout
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], din};
      end
   end

   assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/pwm_sar_controller.sv
// rtl/pwm_sar_controller.sv - successive-approximation sequencer for a PWM-DAC and comparator ADC
// Ports:
//   clk          in  1      : system clock
//   reset        in  1      : synchronous, active-low
//   start        in  1      : request one conversion (sampled in IDLE only)
//   continuous   in  1      : re-arm after DONE (sampled in DONE)
//   comp_in      in  1      : raw comparator, 1 = Vin >= Vdac(dac_code)
//   dac_code     out DATA_W : trial code for the PWM duty register
//   busy         out 1      : high in every state except IDLE
//   result       out DATA_W : last completed conversion
//   result_valid out 1      : one-cycle pulse when result updates
module pwm_sar_controller
   import adc_pkg::*;
#(
   parameter int DATA_W        = ADC_DATA_W,
   parameter int SETTLE_CYCLES = ADC_SETTLE_CYCLES,
   parameter int SYNC_STAGES   = ADC_SYNC_STAGES
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              continuous,
   input  logic              comp_in,
   output logic [DATA_W-1:0] dac_code,
   output logic              busy,
   output logic [DATA_W-1:0] result,
   output logic              result_valid
);

   localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

   localparam logic [IDX_W-1:0] MSB_IDX     = IDX_W'(DATA_W - 1);
   // SETTLE exits on the cycle the counter reads 0, so loading N-1 gives N cycles.
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

   sar_state_t        state;
   logic [IDX_W-1:0]  bit_idx;
   logic [CNT_W-1:0]  settle_cnt;
   logic [DATA_W-1:0] code;
   logic [DATA_W-1:0] trial_bit;
   logic              comp_sync;

   bit_sync #(
      .STAGES (SYNC_STAGES)
   ) u_comp_sync (
      .clk   (clk),
      .reset (reset),
      .din   (comp_in),
      .dout  (comp_sync)
   );

   assign trial_bit = {{(DATA_W-1){1'b0}}, 1'b1} << bit_idx;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= IDLE;
         bit_idx      <= '0;
         settle_cnt   <= '0;
         code         <= '0;
         dac_code     <= '0;
         result       <= '0;
         result_valid <= 1'b0;
         busy         <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= SET;
                  bit_idx <= MSB_IDX;
                  code    <= '0;
                  busy    <= 1'b1;
               end
            end
            SET: begin
               dac_code   <= code | trial_bit;
               settle_cnt <= SETTLE_LOAD;
               state      <= SETTLE;
            end
            SETTLE: begin
               if (settle_cnt == '0) begin
                  state <= SAMPLE;
               end else begin
                  settle_cnt <= settle_cnt - 1'b1;
               end
            end
            SAMPLE: begin
               // Only the synchronised comparator is trusted; the trial bit is kept on 1.
               if (comp_sync) begin
                  code <= code | trial_bit;
               end
               if (bit_idx == '0) begin
                  state <= DONE;
               end else begin
                  bit_idx <= bit_idx - 1'b1;
                  state   <= SET;
               end
            end
            DONE: begin
               result       <= code;
               result_valid <= 1'b1;
               if (continuous) begin
                  state   <= SET;
                  bit_idx <= MSB_IDX;
                  code    <= '0;
                  busy    <= 1'b1;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_sar_controller.sv
// tb/tb_pwm_sar_controller.sv - directed self-checking bench for pwm_sar_controller
module tb_pwm_sar_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       continuous = 1'b0;
   logic       comp_in;
   logic [7:0] dac_code;
   logic       busy;
   logic [7:0] result;
   logic       result_valid;

   logic [7:0] vin = 8'h00;
   logic       glitch_on = 1'b0;
   logic       glitch_val = 1'b0;

   int total = 0;
   int bad = 0;

   int         rv_cnt;
   int         rv1_n;
   int         rv2_n;
   logic [7:0] rv1_res;
   logic [7:0] rv2_res;
   int         busy_low_n;
   logic       busy48;
   logic       step_bad;
   logic [7:0] seq[$];
   logic [7:0] exp_seq[8];

   always #5 clk = ~clk;

   // Comparator model: ideal comparator, optionally overridden with a glitch pattern.
   assign comp_in = glitch_on ? glitch_val : (vin >= dac_code);

   pwm_sar_controller #(
      .DATA_W        (8),
      .SETTLE_CYCLES (4),
      .SYNC_STAGES   (2)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .continuous   (continuous),
      .comp_in      (comp_in),
      .dac_code     (dac_code),
      .busy         (busy),
      .result       (result),
      .result_valid (result_valid)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One start pulse at cycle 0, then `cycles` clocks. Cycle n counts posedges after the
   // start posedge; within a conversion, position 0 is SET and position 5 is SAMPLE.
   task automatic run(input logic [7:0] va, input logic [7:0] vb, input int cycles,
                      input int extra_n, input int cont_clear_n, input int rst_at,
                      input bit glitch);
      int         k;
      int         pos;
      logic [7:0] prev;
      rv_cnt = 0; rv1_n = 0; rv2_n = 0; rv1_res = 8'h00; rv2_res = 8'h00;
      busy_low_n = 0; busy48 = 1'b0; step_bad = 1'b0;
      seq.delete();
      vin  = va;
      prev = dac_code;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 1; n <= cycles; n++) begin
         k   = (n - 1) % 49;
         pos = k % 6;
         start      = (n == extra_n);
         if (n == cont_clear_n) continuous = 1'b0;
         glitch_on  = glitch && (n <= 48) && (pos == 1 || pos == 2);
         glitch_val = n[0];
         reset      = (n == rst_at) ? 1'b0 : 1'b1;
         tick();
         if (n == rst_at) begin
            check("rst_dac_code", dac_code, 8'h00);
            check("rst_result", result, 8'h00);
            check("rst_busy", busy, 1'b0);
            check("rst_result_valid", result_valid, 1'b0);
            prev = dac_code;
         end
         if (dac_code !== prev) begin
            seq.push_back(dac_code);
            if (pos != 0) step_bad = 1'b1;
            prev = dac_code;
         end
         if (result_valid) begin
            rv_cnt++;
            if (rv_cnt == 1) begin
               rv1_n = n; rv1_res = result; vin = vb;
            end else if (rv_cnt == 2) begin
               rv2_n = n; rv2_res = result;
            end
         end
         if (!busy && busy_low_n == 0) busy_low_n = n;
         if (n == 48) busy48 = busy;
      end
      start = 1'b0; glitch_on = 1'b0; reset = 1'b1;
   endtask

   initial begin
      exp_seq = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

      // Reset state
      reset = 1'b0;
      tick();
      tick();
      check("reset_dac_code", dac_code, 8'h00);
      check("reset_result", result, 8'h00);
      check("reset_result_valid", result_valid, 1'b0);
      check("reset_busy", busy, 1'b0);
      reset = 1'b1;
      tick();

      // 1: vin=0xA5, single conversion
      run(8'hA5, 8'hA5, 58, 0, 0, 0, 1'b0);
      check("t1_seq_len", seq.size(), 8);
      for (int i = 0; i < 8; i++) begin
         if (i < seq.size()) check($sformatf("t1_seq%0d", i), seq[i], exp_seq[i]);
      end
      check("t1_latency", rv1_n, 49);
      check("t1_result", rv1_res, 8'hA5);
      check("t1_rv_count", rv_cnt, 1);
      check("t1_busy_during", busy48, 1'b1);
      check("t1_busy_fall", (busy_low_n == 49 || busy_low_n == 50), 1'b1);
      check("t1_busy_idle", busy, 1'b0);
      check("t1_dac_hold", dac_code, 8'hA5);

      // 2: full-scale and zero-scale
      run(8'hFF, 8'hFF, 58, 0, 0, 0, 1'b0);
      check("t2_ff_result", rv1_res, 8'hFF);
      check("t2_ff_latency", rv1_n, 49);
      check("t2_ff_set_only", step_bad, 1'b0);
      run(8'h00, 8'h00, 58, 0, 0, 0, 1'b0);
      check("t2_00_result", rv1_res, 8'h00);
      check("t2_00_latency", rv1_n, 49);
      check("t2_00_set_only", step_bad, 1'b0);
      check("t2_00_final_trial", dac_code, 8'h01);

      // 3: continuous mode, vin changes after the first result
      continuous = 1'b1;
      run(8'h10, 8'h3C, 100, 0, 60, 0, 1'b0);
      check("t3_first_n", rv1_n, 49);
      check("t3_first_result", rv1_res, 8'h10);
      check("t3_period", rv2_n - rv1_n, 49);
      check("t3_second_result", rv2_res, 8'h3C);
      check("t3_rv_count", rv_cnt, 2);
      check("t3_busy_held", (busy_low_n == 0 || busy_low_n >= 98), 1'b1);
      check("t3_set_only", step_bad, 1'b0);

      // 4: extra start during SETTLE of bit 5
      run(8'h77, 8'h77, 58, 15, 0, 0, 1'b0);
      check("t4_rv_count", rv_cnt, 1);
      check("t4_latency", rv1_n, 49);
      check("t4_result", rv1_res, 8'h77);

      // 5: reset during SAMPLE of bit 3, then a clean conversion
      run(8'h3C, 8'h3C, 58, 0, 0, 30, 1'b0);
      check("t5_no_rv", rv_cnt, 0);
      check("t5_idle_after", busy, 1'b0);
      run(8'h5A, 8'h5A, 58, 0, 0, 0, 1'b0);
      check("t5_new_result", rv1_res, 8'h5A);
      check("t5_new_latency", rv1_n, 49);

      // 6: comparator toggling during SETTLE, correct through the sampling window
      run(8'h69, 8'h69, 58, 0, 0, 0, 1'b1);
      check("t6_result", rv1_res, 8'h69);
      check("t6_rv_count", rv_cnt, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
